// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  mode_e              i_mode,
  input  logic [2*WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0]   i_rem,
  input  logic [WIDTH-1:0]   i_quo,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH:0]   o_acc,
  output logic [WIDTH-1:0]   o_rem,
  output logic [WIDTH-1:0]   o_quo
);

  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH:0] w_acc_add;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic             w_unused_trial_msb;

  assign w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_b};
  assign w_acc_add = i_acc[0] ? {w_sum, i_acc[WIDTH-1:0]} : i_acc;
  // Remainder needs one extra bit after the shift before the trial subtract.
  assign w_rem_sh  = {i_rem, i_quo[WIDTH-1]};
  assign w_fits    = (w_rem_sh >= {1'b0, i_b});
  assign w_trial   = w_rem_sh - {1'b0, i_b};
  assign w_unused_trial_msb = w_trial[WIDTH];

  always_comb begin
    o_acc = i_acc;
    o_rem = i_rem;
    o_quo = i_quo;
    if (i_mode == MODE_MUL) begin
      o_acc = {1'b0, w_acc_add[2*WIDTH:1]};
    end else if (w_fits) begin
      o_rem = w_trial[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_rem_sh[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULTU/DIVU unit with architectural HI/LO and datapath stall.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_hlread,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done
);

  state_e             r_state, w_state_nxt;
  logic [CNTW-1:0]    r_cnt, w_cnt_nxt;
  logic [2*WIDTH:0]   r_acc, w_acc_nxt;
  logic [WIDTH-1:0]   r_rem, w_rem_nxt;
  logic [WIDTH-1:0]   r_quo, w_quo_nxt;
  logic [WIDTH-1:0]   r_b, w_b_nxt;
  logic [WIDTH-1:0]   r_hi, w_hi_nxt;
  logic [WIDTH-1:0]   r_lo, w_lo_nxt;
  logic               r_done, w_done_nxt;

  mode_e              w_mode;
  logic [2*WIDTH:0]   w_step_acc;
  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_step_quo;
  logic               w_last;

  assign w_mode = (r_state == S_DIV) ? MODE_DIV : MODE_MUL;
  assign w_last = (r_cnt == CNTW'(WIDTH - 1));

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_mode (w_mode),
    .i_acc  (r_acc),
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_b    (r_b),
    .o_acc  (w_step_acc),
    .o_rem  (w_step_rem),
    .o_quo  (w_step_quo)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_quo_nxt   = r_quo;
    w_b_nxt     = r_b;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          unique case (op_e'(i_op))
            OP_MULTU: begin
              w_b_nxt     = i_b;
              w_acc_nxt   = {{(WIDTH + 1){1'b0}}, i_a};
              w_cnt_nxt   = '0;
              w_state_nxt = S_MUL;
            end
            OP_DIVU: begin
              w_b_nxt     = i_b;
              w_rem_nxt   = '0;
              w_quo_nxt   = i_a;
              w_cnt_nxt   = '0;
              w_state_nxt = S_DIV;
            end
            OP_MTHI: w_hi_nxt = i_a;
            OP_MTLO: w_lo_nxt = i_a;
          endcase
        end
      end
      S_MUL: begin
        w_acc_nxt = w_step_acc;
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) begin
          w_hi_nxt    = w_step_acc[2*WIDTH-1:WIDTH];
          w_lo_nxt    = w_step_acc[WIDTH-1:0];
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DIV: begin
        w_rem_nxt = w_step_rem;
        w_quo_nxt = w_step_quo;
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) begin
          w_hi_nxt    = w_step_rem;
          w_lo_nxt    = w_step_quo;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_b     <= w_b_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = r_done;
  // Any issue or HI/LO read must wait while an operation is in flight.
  assign o_stall = o_busy & (i_start | i_hlread);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hlread;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] o_hi, o_lo;
  logic         o_busy, o_stall, o_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] exp_v;
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;
  int             m_left = 0;
  bit             m_done_pend = 1'b0;
  int             busy_run = 0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .WIDTH (W),
    .CNTW  (6)
  ) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (start),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .i_hlread (hlread),
    .o_hi     (o_hi),
    .o_lo     (o_lo),
    .o_busy   (o_busy),
    .o_stall  (o_stall),
    .o_done   (o_done)
  );

  function automatic logic [2*W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
    logic [2*W-1:0] r;
    if (o == OP_MULTU) r = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    else if (y == 0)   r = {x, {W{1'b1}}};
    else               r = {x % y, x / y};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle latency model plus scoreboard pop on each done pulse.
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      check("busy", {63'b0, o_busy}, {63'b0, m_left > 0});
      check("stall", {63'b0, o_stall}, {63'b0, (m_left > 0) && (start || hlread)});
      check("done", {63'b0, o_done}, {63'b0, m_done_pend});
      if (o_done) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_unexpected: got done=1 expected no pending result");
        end else begin
          exp_v = sb_q.pop_front();
          check("sb_hi", 64'(o_hi), 64'(exp_v[2*W-1:W]));
          check("sb_lo", 64'(o_lo), 64'(exp_v[W-1:0]));
          m_hi = exp_v[2*W-1:W];
          m_lo = exp_v[W-1:0];
        end
        check("busy_len", 64'(busy_run), 64'(W));
        busy_run = 0;
      end
      check("hi_hold", 64'(o_hi), 64'(m_hi));
      check("lo_hold", 64'(o_lo), 64'(m_lo));
      if (o_busy) busy_run++;
      m_done_pend = (m_left == 1);
      if (m_left > 0) m_left--;
    end
  end

  // Called at posedge+#1; returns at posedge+#1 of the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int waited = 0;
    bit acc = 1'b0;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    while (!acc && waited < 3 * W) begin
      @(negedge clk);
      if (!o_stall) acc = 1'b1;
      else waited++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("accept", {63'b0, acc}, 64'd1);
    if (acc) begin
      case (o)
        OP_MULTU, OP_DIVU: begin
          sb_q.push_back(ref_result(o, x, y));
          m_left = W;
        end
        OP_MTHI: begin
          m_hi = x;
          check("mthi_hi", 64'(o_hi), 64'(x));
          check("mthi_lo", 64'(o_lo), 64'(m_lo));
        end
        default: begin
          m_lo = x;
          check("mtlo_lo", 64'(o_lo), 64'(x));
          check("mtlo_hi", 64'(o_hi), 64'(m_hi));
        end
      endcase
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((m_left > 0 || m_done_pend) && c < 4 * W) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("idle_reached", {63'b0, c < 4 * W}, 64'd1);
  endtask

  initial begin
    int sc;
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;
    logic [2*W-1:0] e;
    reset = 1'b1; start = 1'b0; hlread = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_hi", 64'(o_hi), 64'd0);
    check("reset_lo", 64'(o_lo), 64'd0);
    check("reset_busy", {63'b0, o_busy}, 64'd0);
    check("reset_done", {63'b0, o_done}, 64'd0);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    check("mul_max_hi", 64'(o_hi), 64'hFFFF_FFFE);
    check("mul_max_lo", 64'(o_lo), 64'h0000_0001);

    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle();
    check("div100_hi", 64'(o_hi), 64'd2);
    check("div100_lo", 64'(o_lo), 64'd14);
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_idle();
    check("div0_hi", 64'(o_hi), 64'd5);
    check("div0_lo", 64'(o_lo), 64'hFFFF_FFFF);

    issue(OP_MTHI, 32'h1234, 32'h0);
    issue(OP_MTLO, 32'hABCD, 32'h0);
    check("mt_hi", 64'(o_hi), 64'h1234);
    check("mt_lo", 64'(o_lo), 64'hABCD);

    // HI/LO read held off until the product commits.
    issue(OP_MULTU, 32'd3, 32'd4);
    @(posedge clk);
    #1 hlread = 1'b1;
    sc = 0;
    while (sc < 3 * W) begin
      @(negedge clk);
      if (!o_stall) break;
      sc++;
    end
    check("hl_stall_cycles", 64'(sc), 64'(W - 1));
    check("hl_lo", 64'(o_lo), 64'd12);
    check("hl_hi", 64'(o_hi), 64'd0);
    check("hl_done", {63'b0, o_done}, 64'd1);
    @(posedge clk);
    #1 hlread = 1'b0;

    // Abort a divide mid-flight.
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    sb_q.delete();
    m_left = 0; m_done_pend = 1'b0; m_hi = '0; m_lo = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_hi", 64'(o_hi), 64'd0);
    check("abort_lo", 64'(o_lo), 64'd0);
    check("abort_busy", {63'b0, o_busy}, 64'd0);
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_idle();
    check("mul67_lo", 64'(o_lo), 64'd42);

    // DIVU issued while MULTU busy: product commits first, then the quotient.
    issue(OP_MULTU, 32'h0001_2345, 32'h0000_6789);
    issue(OP_DIVU, 32'hDEAD_BEEF, 32'h0000_1234);
    wait_idle();
    check("b2b_hi", 64'(o_hi), 64'(32'hDEAD_BEEF % 32'h1234));
    check("b2b_lo", 64'(o_lo), 64'(32'hDEAD_BEEF / 32'h1234));

    for (int i = 0; i < 30; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = '0;
        1:       r_b = W'($urandom_range(1, 15));
        default: r_b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) r_a = W'($urandom_range(0, 255));
      issue(r_op, r_a, r_b);
      repeat ($urandom_range(0, 2)) begin
        hlread = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      hlread = 1'b0;
    end
    wait_idle();
    e = {m_hi, m_lo};
    check("final_hilo", {o_hi, o_lo}, e);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
